// File: rtl/fir_stage.sv
// 32-tap streaming FIR: serial coefficient load, then one signed sample in and one
// floor-scaled, saturated sample out per clock with a three-register pipeline.
module fir_stage #(
    parameter int TAPS   = 32,
    parameter int DATA_W = 16,
    parameter int COEF_W = 20,
    parameter int FRAC_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     coef_valid,
    input  logic signed [COEF_W-1:0] coef_d,
    output logic                     coef_done,
    input  logic                     data_valid,
    input  logic signed [DATA_W-1:0] data,
    output logic                     fir_valid,
    output logic signed [DATA_W-1:0] fir_d
);

    localparam int CNT_W   = $clog2(TAPS);
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ACC_W   = PROD_W + $clog2(TAPS);
    localparam int OUT_MAX = 2 ** (DATA_W - 1) - 1;
    localparam int OUT_MIN = -(2 ** (DATA_W - 1));

    typedef enum logic [1:0] {
        S_LOAD,
        S_FILL,
        S_RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   coef_cnt_q;
    logic [CNT_W-1:0]   fill_cnt_q;
    logic               coef_we;
    logic               shift_en;
    logic               vld_in;

    logic signed [COEF_W-1:0] h_q     [TAPS];
    logic signed [DATA_W-1:0] x_p0    [TAPS];
    logic                     vld_p0;
    logic signed [PROD_W-1:0] prod_p1 [TAPS];
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] fir_d_p2;
    logic                     vld_p2;

    function automatic logic signed [ACC_W-1:0] shift_floor(input logic signed [ACC_W-1:0] v);
        return v >>> FRAC_W;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > ACC_W'(OUT_MAX)) begin
            return DATA_W'(OUT_MAX);
        end else if (v < ACC_W'(OUT_MIN)) begin
            return DATA_W'(OUT_MIN);
        end
        return v[DATA_W-1:0];
    endfunction

    // Data is dropped in LOAD, including a sample coinciding with the last coefficient.
    always_comb begin
        state_d  = state_q;
        coef_we  = 1'b0;
        shift_en = 1'b0;
        vld_in   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (coef_valid) begin
                    coef_we = 1'b1;
                    if (coef_cnt_q == CNT_W'(TAPS - 1)) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (data_valid) begin
                    shift_en = 1'b1;
                    if (fill_cnt_q == CNT_W'(TAPS - 1)) begin
                        state_d = S_RUN;
                        vld_in  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (data_valid) begin
                    shift_en = 1'b1;
                    vld_in   = 1'b1;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_LOAD;
            coef_cnt_q <= '0;
            fill_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (coef_we) begin
                coef_cnt_q <= coef_cnt_q + CNT_W'(1);
            end
            if (shift_en && state_q == S_FILL) begin
                fill_cnt_q <= fill_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < TAPS; k++) h_q[k] <= '0;
        end else if (coef_we) begin
            h_q[coef_cnt_q] <= coef_d;
        end
    end

    assign coef_done = (state_q != S_LOAD);

    // Stage 1: sample window shift register
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p0 <= 1'b0;
            for (int k = 0; k < TAPS; k++) x_p0[k] <= '0;
        end else begin
            vld_p0 <= vld_in;
            if (shift_en) begin
                x_p0[0] <= data;
                for (int k = 1; k < TAPS; k++) x_p0[k] <= x_p0[k-1];
            end
        end
    end

    // Stage 2: per-tap products
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1 <= 1'b0;
            for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
        end else begin
            vld_p1 <= vld_p0;
            for (int k = 0; k < TAPS; k++) begin
                prod_p1[k] <= PROD_W'(x_p0[k]) * PROD_W'(h_q[k]);
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc_sum = acc_sum + ACC_W'(prod_p1[k]);
        end
    end

    // Stage 3: sum, floor shift, saturate; output holds between valid beats
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p2   <= 1'b0;
            fir_d_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                fir_d_p2 <= saturate(shift_floor(acc_sum));
            end
        end
    end

    assign fir_valid = vld_p2;
    assign fir_d     = fir_d_p2;

endmodule

// File: tb/tb_fir_stage.sv
// Scoreboard bench for fir_stage: stimulus pushes expected value and arrival cycle,
// a negedge monitor pops and compares on every fir_valid beat.
module tb_fir_stage;

    logic               CLK = 1'b0;
    logic               RST;
    logic               coef_valid;
    logic signed [19:0] coef_d;
    logic               coef_done;
    logic               data_valid;
    logic signed [15:0] data;
    logic               fir_valid;
    logic signed [15:0] fir_d;

    fir_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .coef_valid (coef_valid),
        .coef_d     (coef_d),
        .coef_done  (coef_done),
        .data_valid (data_valid),
        .data       (data),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   hold_exp = 0;
    logic rst_q    = 1'b0;
    int   coef_tab[32];

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: consumes one scoreboard entry per output beat, checks hold otherwise.
    always @(negedge CLK) begin
        if (rst_q) hold_exp = 0;
        if (fir_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", int'(fir_valid), 0);
            end else begin
                e_mon = sb_q.pop_front();
                check("fir_d", fir_d, e_mon.val);
                check("fir_valid_cycle", cyc, e_mon.cyc);
                hold_exp = e_mon.val;
            end
        end else begin
            check("fir_d_hold", fir_d, hold_exp);
            if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e_mon = sb_q.pop_front();
                check("missing_valid", int'(fir_valid), 1);
            end
        end
    end

    task automatic drive(input logic rst, input logic cv, input int cd, input logic dv, input int d);
        @(posedge CLK);
        #1;
        RST        = rst;
        coef_valid = cv;
        coef_d     = cd[19:0];
        data_valid = dv;
        data       = d[15:0];
    endtask

    task automatic expect_out(input int val);
        exp_t t;
        t.cyc = cyc + 3;
        t.val = val;
        sb_q.push_back(t);
    endtask

    task automatic send(input int s, input bit has_out, input int exp_v,
                        input bit cv = 1'b0, input int cd = 0);
        drive(1'b0, cv, cd, 1'b1, s);
        if (has_out) expect_out(exp_v);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0, 1'b0, 0);
        while (sb_q.size() > 0 && sb_q[$].cyc > cyc) void'(sb_q.pop_back());
        idle(1);
        check("rst_fir_valid", int'(fir_valid), 0);
        check("rst_fir_d", fir_d, 0);
        check("rst_coef_done", int'(coef_done), 0);
    endtask

    task automatic load(input bit with_data);
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b1, coef_tab[k], with_data, 777);
        end
        check("coef_done_before_last", int'(coef_done), 0);
        idle(1);
        check("coef_done_after_last", int'(coef_done), 1);
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    int flr_in[6]  = '{-3, 3, -1, 1, 32767, -32768};
    int flr_exp[6] = '{-2, 1, -1, 0, 16383, -16384};

    initial begin
        RST        = 1'b1;
        coef_valid = 1'b0;
        coef_d     = '0;
        data_valid = 1'b0;
        data       = '0;

        // Single-tap pass-through, one-cycle valid gap, ignored coefficients in RUN
        foreach (coef_tab[k]) coef_tab[k] = 0;
        coef_tab[0] = 65536;
        do_reset();
        load(1'b0);
        for (int s = 1; s <= 40; s++) begin
            send(s, s >= 32, s, s >= 36, 131072);
            if (s == 35) idle(1);
        end
        idle(4);

        // Sum and saturation with all taps at 1.0; data offered during load is dropped
        foreach (coef_tab[k]) coef_tab[k] = 65536;
        do_reset();
        load(1'b1);
        for (int i = 1; i <= 40; i++) send(1000, i >= 32, 32000);
        for (int k = 1; k <= 32; k++) send(2000, 1'b1, clamp16(1000 * (32 - k) + 2000 * k));
        for (int k = 1; k <= 32; k++) send(-2000, 1'b1, clamp16(2000 * (32 - k) - 2000 * k));
        idle(4);

        // Floor rounding with h0 = 0.5
        foreach (coef_tab[k]) coef_tab[k] = 0;
        coef_tab[0] = 32768;
        do_reset();
        load(1'b0);
        for (int i = 0; i < 31; i++) send(0, 1'b0, 0);
        for (int i = 0; i < 6; i++) send(flr_in[i], 1'b1, flr_exp[i]);

        // Reset mid-RUN: in-flight outputs vanish, samples ignored until reload and refill
        send(10, 1'b1, 5);
        send(20, 1'b1, 10);
        send(40, 1'b1, 20);
        do_reset();
        for (int i = 0; i < 5; i++) send(55, 1'b0, 0);
        check("coef_done_after_rst_data", int'(coef_done), 0);
        foreach (coef_tab[k]) coef_tab[k] = 0;
        coef_tab[0] = 65536;
        load(1'b1);
        for (int s = 101; s <= 140; s++) send(s, s >= 132, s);
        idle(1);

        begin
            int w = 0;
            while (sb_q.size() > 0 && w < 20) begin
                @(posedge CLK);
                w++;
            end
            check("scoreboard_drained", sb_q.size(), 0);
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fir_stage.md
# fir_stage

Streaming 32-tap FIR filter at the front of the frequency-analysis datapath. It accepts one signed 16-bit sample per clock and produces one filtered signed 16-bit sample per clock on `fir_valid`/`fir_d`. The serial-to-parallel stage directly downstream consumes these and frames them into 16-sample blocks for the FFT. Coefficients are loaded serially after reset, before any data is accepted.

## Interface
- `TAPS`, 32: filter length. Fixed; the counters below are sized for 32.
- `CLK` input 1: clock. All logic is on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `coef_valid` input 1: the coefficient beat is valid.
- `coef_d` input 20: signed coefficient, Q4.16 (16 fractional bits).
- `coef_done` output 1: high once all 32 coefficients are loaded.
- `data_valid` input 1: the input sample is valid.
- `data` input 16: signed input sample.
- `fir_valid` output 1: output sample valid. Asserted for one cycle per output sample.
- `fir_d` output 16: signed filtered sample.

## Operation
- Filter equation: y[n] = Σ h[k]·x[n−k], k = 0..31, where h[k] is the k-th coefficient beat after reset.
- Tap storage: shift register x[0..31], with x[0] the newest sample. It shifts only on an accepted `data_valid`.
- The state machine has three states:
  - **LOAD** (reset state):
    - Each `coef_valid` writes `coef_d` to h[coef_cnt], then increments `coef_cnt` (5-bit).
    - On the 32nd beat the block moves to FILL and `coef_done` goes to 1.
    - `data_valid` is ignored in LOAD.
  - **FILL**:
    - Each `data_valid` shifts in a sample and increments `fill_cnt` (5-bit).
    - On the 32nd sample (`fill_cnt` == 31) the block moves to RUN.
  - **RUN**: each `data_valid` shifts in a sample.
  - `coef_valid` is ignored in FILL and RUN.
- Arithmetic:
  - Each product is 16×20 bits, giving 36 bits signed.
  - The 32-term sum is 41 bits signed; no overflow is possible at that width.
  - Scaling: arithmetic right shift by 16, which floors (rounds toward −∞).
  - The shifted value then saturates to [−32768, 32767].
- Output valid condition: an output is generated for a sample accepted in RUN, and for the 32nd sample accepted in FILL.
- Output hold: `fir_d` keeps its last value while `fir_valid` = 0.
- Reset effect: `RST` clears h[], x[], both counters, and all pipeline registers. The state returns to LOAD.
- Reset mid-operation: the coefficients must be reloaded, and the window must refill with 32 new samples before the next `fir_valid`.

## Timing
- Reset values: `fir_valid` = 0, `fir_d` = 0, `coef_done` = 0.
- Pipeline stages:
  - Stage 1: the shift register updates, and v0 is registered.
  - Stage 2: the 32 products are registered, and v1 is registered.
  - Stage 3: sum, shift and saturate, registered into `fir_d` and `fir_valid`.
- Latency: the sample accepted at edge t produces its output on `fir_valid`/`fir_d` after edge t+2, so it is visible during the cycle that follows that edge.
- Throughput is one sample per clock. Back-to-back `data_valid` gives back-to-back `fir_valid`.
- Gaps: a gap in `data_valid` produces a gap of the same length in `fir_valid`, two cycles later.
- `coef_done` rises in the cycle after the edge that captures the 32nd coefficient.
- Simultaneous `coef_valid` and `data_valid`:
  - In LOAD, only the coefficient is taken.
  - A sample presented in the same cycle as the 32nd coefficient beat is dropped.
- `RST` has priority over every other input. In the cycle after `RST` is sampled high, all outputs are at their reset values, including any outputs that were in flight in the pipeline.
- There is no backpressure. The downstream stage must accept every `fir_valid` beat.

## Test plan
- **Single-tap pass-through**
  - Stimulus: h0 = 65536, others 0; stream 1, 2, 3, … on consecutive cycles.
  - Required: first `fir_valid` two edges after sample 32, with `fir_d` = 32; then 33, 34, … every cycle.
- **Sum and saturation**
  - Stimulus: all h = 65536; 32+ samples of 1000.
  - Required: `fir_d` = 32000.
  - Then switch to 2000: after a full window, `fir_d` = 32767.
  - Then switch to −2000: `fir_d` = −32768.
- **Floor rounding**
  - Stimulus: h0 = 32768, others 0.
  - Required: sample −3 gives −2; sample 3 gives 1; sample −1 gives −1.
- **Valid gap**
  - Stimulus: 40 samples with `data_valid` low for exactly one cycle after sample 35.
  - Required: `fir_valid` is low for exactly one cycle, two cycles later; the output values are unaffected.
- **Reset mid-RUN**
  - Stimulus: assert `RST` for one cycle while streaming.
  - Required: next cycle `fir_valid` = 0, `fir_d` = 0, `coef_done` = 0.
  - Samples are then ignored until 32 coefficients have been reloaded.
- **Ignored coefficients**
  - Stimulus: `coef_valid` pulses with new values during RUN.
  - Required: the output matches the originally loaded coefficients.
